// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage mreq/mres handshake.
// Services one request at a time: optional wait states, one access cycle, then a one-cycle mres pulse.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mreq,
  input  logic [3:0]        w_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              mres,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                capture_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [3:0]          wen_r;
  logic [31:0]         wdata_r;
  logic [31:0]         load_data_r;
  logic                mres_r;
  logic                busy_r;
  logic                in_range_s;
  logic [IDX_W-1:0]    idx_s;
  logic [31:0]         rd_word_s;
  logic [31:0]         mem_r [DEPTH];

  // No wrap-around: anything at or beyond DEPTH is out of range.
  assign in_range_s = ({1'b0, addr_r} < DEPTH_LIM);
  assign idx_s      = addr_r[IDX_W-1:0];
  assign rd_word_s  = mem_r[idx_s];

  // Next-state and capture decode for the request FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mreq) begin
          capture_s = 1'b1;
          cnt_s     = {CNT_W{1'b0}};
          if (WAIT_CYCLES > 0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_ACCESS;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_ACCESS;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_ACCESS: state_s = ST_RESP;
      ST_RESP:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, captured request, load data and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      wen_r       <= 4'b0000;
      wdata_r     <= 32'h0000_0000;
      load_data_r <= 32'h0000_0000;
      mres_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        addr_r  <= addr_mem;
        wen_r   <= w_mem;
        wdata_r <= store_data;
      end
      if ((state_r == ST_ACCESS) && (wen_r == 4'b0000)) begin
        load_data_r <= in_range_s ? rd_word_s : 32'h0000_0000;
      end
      mres_r <= (state_s == ST_RESP);
      busy_r <= (state_s != ST_IDLE);
    end
  end

  // Single-port array write; the array is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_ACCESS) && in_range_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_r[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign load_data = load_data_r;
  assign mres      = mres_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1/0/3, DEPTH 256/128/256) against a word-array model.
module tb_dmem_responder;

  function automatic int wc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int depth_of(input int k);
    return (k == 1) ? 128 : 256;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mreq [3];
  logic [3:0]  w_mem [3];
  logic [7:0]  addr_mem [3];
  logic [31:0] store_data [3];
  logic [31:0] load_data [3];
  logic        mres [3];
  logic        busy [3];

  int          total = 0;
  int          bad = 0;
  logic [31:0] mdl [3][256];
  logic [31:0] last_ld [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W(8),
      .DEPTH(depth_of(g)),
      .WAIT_CYCLES(wc_of(g))
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .mreq(mreq[g]),
      .w_mem(w_mem[g]),
      .addr_mem(addr_mem[g]),
      .store_data(store_data[g]),
      .load_data(load_data[g]),
      .mres(mres[g]),
      .busy(busy[g])
    );
  end

  // Reference: loads return the word (0 if out of range), stores update enabled lanes in range.
  task automatic mdl_op(input int k, input logic [3:0] w, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] exp_ld);
    if (w == 4'h0) begin
      exp_ld = (int'(a) < depth_of(k)) ? mdl[k][a] : 32'h0;
      last_ld[k] = exp_ld;
    end else begin
      if (int'(a) < depth_of(k)) begin
        for (int i = 0; i < 4; i++) begin
          if (w[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
        end
      end
      exp_ld = last_ld[k];
    end
  endtask

  // Issues one request, holds mreq until mres, and measures timing over a 10-cycle window.
  task automatic run_req(input int k, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d,
                         output int lat, output int width, output logic [31:0] ld, output bit busy_ok);
    lat = -1; width = 0; ld = 32'h0; busy_ok = 1'b1;
    @(negedge clk);
    mreq[k] = 1'b1; w_mem[k] = w; addr_mem[k] = a; store_data[k] = d;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (mres[k]) begin
        if (lat < 0) begin
          lat = c; ld = load_data[k]; mreq[k] = 1'b0;
          w_mem[k] = 4'($urandom); addr_mem[k] = 8'($urandom); store_data[k] = $urandom;
        end
        width++;
      end
      if (busy[k] !== ((lat < 0) || (c == lat))) busy_ok = 1'b0;
    end
    mreq[k] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (mres[k] !== 1'b0) begin bad++; $display("FAIL reset_mres k=%0d got=%b exp=0", k, mres[k]); end
      total++; if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, busy[k]); end
      total++; if (load_data[k] !== 32'h0) begin bad++; $display("FAIL reset_ld k=%0d got=%h exp=0", k, load_data[k]); end
    end
  endtask

  task automatic test_store_load;
    int lat, width; logic [31:0] ld, exp_ld; bit bok;
    run_req(0, 4'hF, 8'h10, 32'hDEADBEEF, lat, width, ld, bok);
    mdl_op(0, 4'hF, 8'h10, 32'hDEADBEEF, exp_ld);
    total++; if (lat != 3) begin bad++; $display("FAIL sl_store_lat got=%0d exp=3", lat); end
    total++; if (width != 1) begin bad++; $display("FAIL sl_store_width got=%0d exp=1", width); end
    total++; if (!bok) begin bad++; $display("FAIL sl_store_busy got=0 exp=1"); end
    run_req(0, 4'h0, 8'h10, 32'h0, lat, width, ld, bok);
    mdl_op(0, 4'h0, 8'h10, 32'h0, exp_ld);
    total++; if (lat != 3) begin bad++; $display("FAIL sl_load_lat got=%0d exp=3", lat); end
    total++; if (ld !== 32'hDEADBEEF) begin bad++; $display("FAIL sl_load_data got=%h exp=deadbeef", ld); end
  endtask

  task automatic test_byte_lanes;
    int lat, width; logic [31:0] ld, exp_ld; bit bok;
    run_req(0, 4'hF, 8'h20, 32'h11223344, lat, width, ld, bok);
    mdl_op(0, 4'hF, 8'h20, 32'h11223344, exp_ld);
    run_req(0, 4'b0101, 8'h20, 32'hAABBCCDD, lat, width, ld, bok);
    mdl_op(0, 4'b0101, 8'h20, 32'hAABBCCDD, exp_ld);
    total++; if (ld !== 32'hDEADBEEF) begin bad++; $display("FAIL bl_store_keeps_ld got=%h exp=deadbeef", ld); end
    run_req(0, 4'h0, 8'h20, 32'h0, lat, width, ld, bok);
    mdl_op(0, 4'h0, 8'h20, 32'h0, exp_ld);
    total++; if (ld !== 32'h11BB33DD) begin bad++; $display("FAIL bl_load got=%h exp=11bb33dd", ld); end
  endtask

  task automatic test_latency;
    int lat, width; logic [31:0] ld, exp_ld, d; bit bok;
    d = $urandom;
    run_req(1, 4'hF, 8'h05, d, lat, width, ld, bok);
    mdl_op(1, 4'hF, 8'h05, d, exp_ld);
    total++; if (lat != 2) begin bad++; $display("FAIL lat_wc0 got=%0d exp=2", lat); end
    total++; if (!bok) begin bad++; $display("FAIL lat_wc0_busy got=0 exp=1"); end
    run_req(2, 4'hF, 8'h05, d, lat, width, ld, bok);
    mdl_op(2, 4'hF, 8'h05, d, exp_ld);
    total++; if (lat != 5) begin bad++; $display("FAIL lat_wc3 got=%0d exp=5", lat); end
    total++; if (width != 1) begin bad++; $display("FAIL lat_wc3_width got=%0d exp=1", width); end
    total++; if (!bok) begin bad++; $display("FAIL lat_wc3_busy got=0 exp=1"); end
  endtask

  task automatic test_held_mreq;
    logic [15:0] seen; logic [31:0] exp_ld;
    seen = 16'h0;
    @(negedge clk);
    mreq[0] = 1'b1; w_mem[0] = 4'h0; addr_mem[0] = 8'h10; store_data[0] = 32'h0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (mres[0]) seen[c] = 1'b1;
      if (c == 5) mreq[0] = 1'b0;
    end
    mdl_op(0, 4'h0, 8'h10, 32'h0, exp_ld);
    mdl_op(0, 4'h0, 8'h10, 32'h0, exp_ld);
    total++; if (seen !== 16'h0088) begin bad++; $display("FAIL held_mres_cycles got=%h exp=0088", seen); end
    total++; if (load_data[0] !== exp_ld) begin bad++; $display("FAIL held_ld got=%h exp=%h", load_data[0], exp_ld); end
  endtask

  task automatic test_reset_mid_store;
    int lat, width; logic [31:0] ld, exp_ld; bit bok;
    run_req(0, 4'hF, 8'h30, 32'h55AA55AA, lat, width, ld, bok);
    mdl_op(0, 4'hF, 8'h30, 32'h55AA55AA, exp_ld);
    @(negedge clk);
    mreq[0] = 1'b1; w_mem[0] = 4'hF; addr_mem[0] = 8'h30; store_data[0] = 32'h0;
    @(posedge clk); #1;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL rms_busy_before got=%b exp=1", busy[0]); end
    reset = 1'b0; #1;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rms_busy_async got=%b exp=0", busy[0]); end
    mreq[0] = 1'b0;
    for (int k = 0; k < 3; k++) last_ld[k] = 32'h0;
    @(posedge clk); @(negedge clk); reset = 1'b1;
    run_req(0, 4'h0, 8'h30, 32'h0, lat, width, ld, bok);
    mdl_op(0, 4'h0, 8'h30, 32'h0, exp_ld);
    total++; if (ld !== 32'h55AA55AA) begin bad++; $display("FAIL rms_load got=%h exp=55aa55aa", ld); end
  endtask

  task automatic test_out_of_range;
    int lat, width; logic [31:0] ld, exp_ld; bit bok;
    run_req(1, 4'hF, 8'h10, 32'hCAFEF00D, lat, width, ld, bok);
    mdl_op(1, 4'hF, 8'h10, 32'hCAFEF00D, exp_ld);
    run_req(1, 4'hF, 8'h90, 32'h12345678, lat, width, ld, bok);
    mdl_op(1, 4'hF, 8'h90, 32'h12345678, exp_ld);
    total++; if (lat != 2) begin bad++; $display("FAIL oor_store_lat got=%0d exp=2", lat); end
    run_req(1, 4'h0, 8'h90, 32'h0, lat, width, ld, bok);
    mdl_op(1, 4'h0, 8'h90, 32'h0, exp_ld);
    total++; if (lat != 2) begin bad++; $display("FAIL oor_load_lat got=%0d exp=2", lat); end
    total++; if (ld !== 32'h0) begin bad++; $display("FAIL oor_load got=%h exp=0", ld); end
    run_req(1, 4'h0, 8'h10, 32'h0, lat, width, ld, bok);
    mdl_op(1, 4'h0, 8'h10, 32'h0, exp_ld);
    total++; if (ld !== 32'hCAFEF00D) begin bad++; $display("FAIL oor_no_wrap got=%h exp=cafef00d", ld); end
  endtask

  task automatic test_random;
    int lat, width; logic [31:0] ld, exp_ld, d; logic [3:0] w; logic [7:0] a; bit bok;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        run_req(k, 4'hF, 8'(i), d, lat, width, ld, bok);
        mdl_op(k, 4'hF, 8'(i), d, exp_ld);
      end
      for (int i = 0; i < 30; i++) begin
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        a = ((k == 1) && ($urandom_range(0, 3) == 0)) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
        d = $urandom;
        run_req(k, w, a, d, lat, width, ld, bok);
        mdl_op(k, w, a, d, exp_ld);
        total++; if (lat != wc_of(k) + 2) begin bad++; $display("FAIL rnd_lat k=%0d i=%0d got=%0d exp=%0d", k, i, lat, wc_of(k) + 2); end
        total++; if (width != 1) begin bad++; $display("FAIL rnd_width k=%0d i=%0d got=%0d exp=1", k, i, width); end
        total++; if (!bok) begin bad++; $display("FAIL rnd_busy k=%0d i=%0d got=0 exp=1", k, i); end
        total++; if (ld !== exp_ld) begin bad++; $display("FAIL rnd_ld k=%0d i=%0d w=%h a=%h got=%h exp=%h", k, i, w, a, ld, exp_ld); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mreq[k] = 1'b0; w_mem[k] = 4'h0; addr_mem[k] = 8'h0; store_data[k] = 32'h0; last_ld[k] = 32'h0;
    end
    test_reset;
    test_store_load;
    test_byte_lanes;
    test_latency;
    test_held_mreq;
    test_reset_mid_store;
    test_out_of_range;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU MEM-stage request handshake (mreq/mres, w_mem, addr_mem, store_data/load_data).
- Owns a word-organised data memory array with byte-lane write enables.
- Services one request at a time with a configurable number of wait states, then returns a one-cycle mres pulse.
- Sits between the MEM stage and the data memory array. The MEM stage uses it to stall its finish signal until mres.

Parameters:
- ADDR_W, 8, word-address width of addr_mem.
- DEPTH, 256, number of 32-bit words implemented (must be <= 2^ADDR_W).
- WAIT_CYCLES, 1, wait states inserted before the access cycle (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mreq  input  1  request from initiator; held high until mres seen.
- w_mem  input  4  byte-lane write enables. 4'b0000 = load; any nonzero value = store to those lanes.
- addr_mem  input  ADDR_W  word address.
- store_data  input  32  store data; lane i = bits [8i+7:8i].
- load_data  output  32  read data; registered.
- mres  output  1  one-cycle response pulse.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mres=0; busy=0; load_data=32'h0; wait counter=0.
  - Memory array contents are not cleared.
  - Reset mid-operation abandons the request. A store not yet past its ACCESS edge writes nothing.
- FSM: IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
  - IDLE: on a rising edge with mreq=1, capture addr_mem, w_mem and store_data into internal registers.
    - Go to WAIT with counter=0 when WAIT_CYCLES>0; otherwise go straight to ACCESS.
  - WAIT: counter increments each cycle; go to ACCESS when counter==WAIT_CYCLES-1.
  - ACCESS: one cycle, using the captured values only.
    - Store: at the closing edge, write lane i of mem[addr] from store_data lane i wherever w_mem[i]=1; other lanes keep their contents.
    - Load: at the closing edge, load_data <= mem[addr].
    - Go to RESP.
  - RESP: mres=1 for exactly this cycle; go to IDLE unconditionally. mreq is ignored during RESP.
- Latency: with mreq sampled high at the edge ending cycle 0, mres is high in cycle WAIT_CYCLES+2.
- Throughput: minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Handshake rules:
  - Initiator drops mreq in the cycle after mres.
  - If mreq is still high in the IDLE cycle after RESP, it is treated as a new request. Initiator must deassert to avoid a duplicate.
  - Input changes after capture have no effect.
- load_data:
  - Valid in the RESP cycle of a load.
  - Held until the next load's ACCESS edge.
  - Stores leave load_data unchanged.
- Read-after-write: a load to an address stored by the previous request returns the new data.
- Out of range (captured addr >= DEPTH):
  - Load returns 32'h0.
  - Store is discarded.
  - mres timing is unchanged.
- There is no address wrap-around: addresses are not taken modulo DEPTH.
- Array is implemented as a synchronous-write register/BRAM-inferable array with a single port.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> mres=0, busy=0, load_data=32'h0.
- Full store/load (WAIT_CYCLES=1):
  - Store w_mem=4'hF, addr=8'h10, data=32'hDEADBEEF -> mres exactly in cycle 3, one cycle wide.
  - Then load from 8'h10 -> load_data=32'hDEADBEEF in its RESP cycle.
- Byte lanes: mem[8'h20]=32'h11223344, then store w_mem=4'b0101, data=32'hAABBCCDD; load 8'h20 -> 32'h11BB33DD.
- Latency sweep: WAIT_CYCLES=0 -> mres in cycle 2; WAIT_CYCLES=3 -> mres in cycle 5; busy high from cycle 1 until the RESP cycle inclusive.
- Held mreq: keep mreq=1 across RESP and one more cycle -> exactly one extra request accepted, in the IDLE cycle after RESP. No mres is generated during the RESP cycle itself.
- Reset mid-store: store 32'h0 to 8'h30 (prior 32'h55AA55AA); pull reset=0 during WAIT -> busy=0 immediately. A subsequent load of 8'h30 returns 32'h55AA55AA.
- Out of range (DEPTH=128): store to 8'h90, then load 8'h90 -> load_data=32'h0, mres timing normal, mem[8'h10] unchanged.
